// File: rtl/ntt_butterfly_unit_if.sv
// Butterfly unit bus: one operand set in, one result pair out.
// The slave side is the butterfly and the master side is its driver.
interface ntt_butterfly_unit_if #(
    parameter int data_width = 12
);
    logic                  i_valid;
    logic                  i_mode;
    logic [data_width-1:0] a_in;
    logic [data_width-1:0] b_in;
    logic [data_width-1:0] w_in;
    logic                  o_valid;
    logic [data_width-1:0] a_out;
    logic [data_width-1:0] b_out;

    modport master (
        output i_valid, i_mode, a_in, b_in, w_in,
        input  o_valid, a_out, b_out
    );

    modport slave (
        input  i_valid, i_mode, a_in, b_in, w_in,
        output o_valid, a_out, b_out
    );
endinterface

// File: rtl/ntt_butterfly_unit.sv
// Kyber radix-2 NTT/INTT butterfly (CT or GS per sample) around a 4-cycle Barrett multiplier, 6-cycle latency.
// Optional macro BFU_INTT_HALF_EN halves both GS results before the output register.
module modular_mul #(
    parameter int                  data_width = 12,
    parameter logic [data_width-1:0] q        = 12'd3329
) (
    input  logic                  clk,
    input  logic [data_width-1:0] A_in,
    input  logic [data_width-1:0] B_in,
    output logic [data_width-1:0] P_out
);
    localparam int K = 2 * data_width;
    // floor(2^K / q); the quotient estimate then undershoots by at most 2
    localparam logic [K:0] BARRETT_M = (K+1)'((64'd1 << K) / 64'(q));
    localparam logic [data_width+1:0] Q_EXT  = {2'b00, q};
    localparam logic [data_width+1:0] Q2_EXT = Q_EXT << 1;

    logic [K-1:0]          prod_p2;
    logic [data_width:0]   qe_p3;
    logic [data_width+1:0] prod_lo_p3;
    logic [data_width+1:0] r_p4;

    // stage 2: full product
    always_ff @(posedge clk) begin
        prod_p2 <= {{data_width{1'b0}}, A_in} * {{data_width{1'b0}}, B_in};
    end

    // stage 3: quotient estimate; only the low bits of the product matter from here on
    always_ff @(posedge clk) begin
        qe_p3      <= (data_width+1)'(({{(K+1){1'b0}}, prod_p2} * {{K{1'b0}}, BARRETT_M}) >> K);
        prod_lo_p3 <= prod_p2[data_width+1:0];
    end

    // stage 4: remainder in [0, 3q), exact modulo 2^(data_width+2)
    always_ff @(posedge clk) begin
        r_p4 <= prod_lo_p3 - ({1'b0, qe_p3} * Q_EXT);
    end

    // stage 5: final correction
    always_ff @(posedge clk) begin
        P_out <= data_width'((r_p4 >= Q2_EXT) ? (r_p4 - Q2_EXT) :
                             (r_p4 >= Q_EXT)  ? (r_p4 - Q_EXT)  : r_p4);
    end
endmodule

module ntt_butterfly_unit #(
    parameter int                  data_width = 12,
    parameter logic [data_width-1:0] q        = 12'd3329
) (
    input  logic                    clk,
    input  logic                    rst,
    ntt_butterfly_unit_if.slave     bfu
);
    function automatic logic [data_width-1:0] mod_add(input logic [data_width-1:0] x,
                                                      input logic [data_width-1:0] y);
        logic [data_width:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return data_width'(s);
    endfunction

    function automatic logic [data_width-1:0] mod_sub(input logic [data_width-1:0] x,
                                                      input logic [data_width-1:0] y);
        logic signed [data_width+1:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        if (d < 0) d = d + $signed({2'b00, q});
        return data_width'(d);
    endfunction

`ifdef BFU_INTT_HALF_EN
    // x * 2^-1 mod q: odd values borrow one q so the shift is exact
    function automatic logic [data_width-1:0] mod_half(input logic [data_width-1:0] x);
        logic [data_width:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return data_width'(t >> 1);
    endfunction
`endif

    logic [data_width-1:0] m_p1, w_p1;
    logic [data_width-1:0] pass_p1, pass_p2, pass_p3, pass_p4, pass_p5;
    logic                  mode_p1, mode_p2, mode_p3, mode_p4, mode_p5;
    logic                  vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
    logic [data_width-1:0] prod_p5;
    logic [data_width-1:0] a_nxt, b_nxt;

    // S1: CT feeds b to the multiplier and passes a; GS feeds a-b and passes a+b
    always_ff @(posedge clk) begin
        m_p1    <= bfu.i_mode ? mod_sub(bfu.a_in, bfu.b_in) : bfu.b_in;
        pass_p1 <= bfu.i_mode ? mod_add(bfu.a_in, bfu.b_in) : bfu.a_in;
        w_p1    <= bfu.w_in;
        mode_p1 <= bfu.i_mode;
    end

    // S2..S5: side data rides alongside the multiplier pipeline
    always_ff @(posedge clk) begin
        pass_p2 <= pass_p1;
        pass_p3 <= pass_p2;
        pass_p4 <= pass_p3;
        pass_p5 <= pass_p4;
        mode_p2 <= mode_p1;
        mode_p3 <= mode_p2;
        mode_p4 <= mode_p3;
        mode_p5 <= mode_p4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
            vld_p5 <= 1'b0;
        end else begin
            vld_p1 <= bfu.i_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
            vld_p5 <= vld_p4;
        end
    end

    modular_mul #(
        .data_width (data_width),
        .q          (q)
    ) u_mul (
        .clk   (clk),
        .A_in  (m_p1),
        .B_in  (w_p1),
        .P_out (prod_p5)
    );

    // S6: combine the aligned pass-through value with the product
    always_comb begin
        a_nxt = mod_add(pass_p5, prod_p5);
        b_nxt = mod_sub(pass_p5, prod_p5);
        if (mode_p5) begin
`ifdef BFU_INTT_HALF_EN
            a_nxt = mod_half(pass_p5);
            b_nxt = mod_half(prod_p5);
`else
            a_nxt = pass_p5;
            b_nxt = prod_p5;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bfu.o_valid <= 1'b0;
            bfu.a_out   <= '0;
            bfu.b_out   <= '0;
        end else begin
            bfu.o_valid <= vld_p5;
            if (vld_p5) begin
                bfu.a_out <= a_nxt;
                bfu.b_out <= b_nxt;
            end
        end
    end
endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Scoreboard bench for ntt_butterfly_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_ntt_butterfly_unit;
    localparam int W = 12;
    localparam int Q = 3329;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_butterfly_unit_if #(.data_width(W)) bif();

    ntt_butterfly_unit #(
        .data_width (W),
        .q          (12'd3329)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bfu (bif)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Golden model: plain % arithmetic, GS halving as a multiply by 2^-1 = 1665
    task automatic gold(input int mode, input int a, input int b, input int w,
                        output int ea, output int eb);
        int t;
        if (mode == 0) begin
            t  = (w * b) % Q;
            ea = (a + t) % Q;
            eb = (a - t + Q) % Q;
        end else begin
            ea = (a + b) % Q;
            eb = (((a - b + Q) % Q) * w) % Q;
`ifdef BFU_INTT_HALF_EN
            ea = (ea * 1665) % Q;
            eb = (eb * 1665) % Q;
`endif
        end
    endtask

    task automatic issue(input int mode, input int a, input int b, input int w,
                         input int ea, input int eb);
        exp_t e;
        bif.i_valid = 1'b1;
        bif.i_mode  = mode[0];
        bif.a_in    = a[W-1:0];
        bif.b_in    = b[W-1:0];
        bif.w_in    = w[W-1:0];
        e.a   = ea[W-1:0];
        e.b   = eb[W-1:0];
        e.cyc = cyc + 6;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bif.i_valid = 1'b0;
        bif.i_mode  = 1'b0;
        bif.a_in    = '0;
        bif.b_in    = '0;
        bif.w_in    = '0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("reset o_valid", 32'(bif.o_valid), 32'd0);
            check("reset a_out", 32'(bif.a_out), 32'd0);
            check("reset b_out", 32'(bif.b_out), 32'd0);
            last_a = '0;
            last_b = '0;
        end else if (bif.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected o_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("o_valid cycle", 32'(cyc), 32'(e.cyc));
                check("a_out", 32'(bif.a_out), 32'(e.a));
                check("b_out", 32'(bif.b_out), 32'(e.b));
                last_a = e.a;
                last_b = e.b;
            end
        end else begin
            check("o_valid idle", 32'(bif.o_valid), 32'd0);
            check("a_out hold", 32'(bif.a_out), 32'(last_a));
            check("b_out hold", 32'(bif.b_out), 32'(last_b));
        end
    end

    initial begin
        int ea, eb, a, b, w, t;
        bif.i_valid = 1'b0;
        bif.i_mode  = 1'b0;
        bif.a_in    = '0;
        bif.b_in    = '0;
        bif.w_in    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // CT basic, isolated so the pulse must be single
        issue(0, 100, 2, 3, 106, 94);
        idle(8);

        // CT wrap and negative cases back to back, then GS
        issue(0, 3000, 1000, 1, 671, 2000);
        issue(0, 5, 10, 1, 15, 3324);
        issue(0, 3328, 3328, 3328, 0, 3327);
`ifdef BFU_INTT_HALF_EN
        issue(1, 10, 3, 5, 1671, 1682);
`else
        issue(1, 10, 3, 5, 13, 35);
`endif
        idle(8);

        // 8 back-to-back butterflies alternating CT/GS
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, Q-1));
            b = int'($urandom_range(0, Q-1));
            w = int'($urandom_range(0, Q-1));
            gold(i % 2, a, b, w, ea, eb);
            issue(i % 2, a, b, w, ea, eb);
        end
        idle(8);

        // gapped stream 1,0,1,1
        issue(0, 100, 2, 3, 106, 94);
        idle(1);
        issue(0, 3000, 1000, 1, 671, 2000);
        issue(0, 5, 10, 1, 15, 3324);
        idle(8);

        // reset three items into a six-item stream
        issue(0, 100, 2, 3, 106, 94);
        issue(0, 5, 10, 1, 15, 3324);
        issue(0, 3000, 1000, 1, 671, 2000);
        rst = 1'b1;
        bif.i_valid = 1'b0;
        sb.delete();
        #1;
        check("async rst o_valid", 32'(bif.o_valid), 32'd0);
        check("async rst a_out", 32'(bif.a_out), 32'd0);
        check("async rst b_out", 32'(bif.b_out), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(10);
        issue(0, 5, 10, 1, 15, 3324);
        idle(10);

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
